io_bus_arbiter: RTL and testbench

Shares the peripheral I/O bus between several bus masters, such as the CPU core and a DMA engine. Each master has a simple request/acknowledge port. The block arbitrates between them round-robin, latches the winning transfer and decodes its address into a one-hot device enable. It then drives the shared `addr`/`data`/`ctrl` bus for exactly one cycle and returns an acknowledge, plus read data for reads. It sits between the masters and the peripheral slaves (LED, UART, GPIO, …), and is the only source of every slave's `EN`.

---
 rtl/io_bus_arbiter_if.sv | 36 +++
 rtl/io_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_bus_arbiter_if : master request ports and shared I/O bus signals.     |
// | Optional err signal with IO_ARB_ERR_EN.  Rev 1.0                         |
// +--------------------------------------------------------------------------+
interface io_bus_arbiter_if #(
   parameter int CPU_WIDTH = 16,
   parameter int REQ_NUM   = 2,
   parameter int DEV_NUM   = 4
);
   logic [REQ_NUM-1:0]           req;
   logic [REQ_NUM-1:0]           req_ctrl;
   logic [REQ_NUM*CPU_WIDTH-1:0] req_addr;
   logic [REQ_NUM*CPU_WIDTH-1:0] req_wdata;
   logic [REQ_NUM-1:0]           ack;
   logic [CPU_WIDTH-1:0]         rdata;
`ifdef IO_ARB_ERR_EN
   logic                         err;
`endif
   logic [CPU_WIDTH-1:0]         bus_addr;
   logic                         bus_ctrl;
   logic [DEV_NUM-1:0]           dev_en;

`ifdef IO_ARB_ERR_EN
   modport master (output req, req_ctrl, req_addr, req_wdata,
                   input  ack, rdata, err, bus_addr, bus_ctrl, dev_en);
   modport slave  (input  req, req_ctrl, req_addr, req_wdata,
                   output ack, rdata, err, bus_addr, bus_ctrl, dev_en);
`else
   modport master (output req, req_ctrl, req_addr, req_wdata,
                   input  ack, rdata, bus_addr, bus_ctrl, dev_en);
   modport slave  (input  req, req_ctrl, req_addr, req_wdata,
                   output ack, rdata, bus_addr, bus_ctrl, dev_en);
`endif
endinterface
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_bus_arbiter : round-robin I/O bus arbiter, one-hot slave enable,      |
// | IDLE/XFER/RESP per transfer. Option IO_ARB_ERR_EN adds err.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module io_bus_arbiter #(
   parameter int CPU_WIDTH = 16,
   parameter int REQ_NUM   = 2,
   parameter int DEV_NUM   = 4,
   parameter int DEV_SHIFT = 12
) (
   input  wire                 clk,
   input  wire                 rst,
   io_bus_arbiter_if.slave     bus,
   inout  wire [CPU_WIDTH-1:0] bus_data
);
   localparam int IDX_W     = $clog2(REQ_NUM);
   localparam int DEV_IDX_W = CPU_WIDTH - DEV_SHIFT;

   localparam logic IO_CTRL_WRITE = 1'b1;
   localparam logic IO_CTRL_READ  = 1'b0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

`ifdef IO_ARB_ERR_EN
   localparam logic [CPU_WIDTH-1:0] UNMAPPED_RDATA = CPU_WIDTH'(32'hDEAD);
`else
   localparam logic [CPU_WIDTH-1:0] UNMAPPED_RDATA = '0;
`endif

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [CPU_WIDTH-1:0] addr_q, addr_d;
   logic                 ctrl_q, ctrl_d;
   logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
   logic [CPU_WIDTH-1:0] rdata_q, rdata_d;

   logic [DEV_IDX_W-1:0] dev_idx;
   logic                 mapped;

   assign dev_idx = addr_q[CPU_WIDTH-1:DEV_SHIFT];
   assign mapped  = (32'(dev_idx) < $unsigned(DEV_NUM));

   // Only a latched write in XFER drives the shared data bus.
   assign bus_data = (state_q == S_XFER && ctrl_q == IO_CTRL_WRITE) ? wdata_q : 'z;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         win_q   <= '0;
         addr_q  <= '0;
         ctrl_q  <= IO_CTRL_READ;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         addr_q  <= addr_d;
         ctrl_q  <= ctrl_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      int   cand;
      logic found;
      cand    = 0;
      found   = 1'b0;
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      addr_d  = addr_q;
      ctrl_d  = ctrl_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            // Search upward from the round-robin pointer, wrapping once.
            for (int k = 0; k < REQ_NUM; k++) begin
               cand = int'(rr_q) + k;
               if (cand >= REQ_NUM) cand = cand - REQ_NUM;
               if (!found && bus.req[cand]) begin
                  found   = 1'b1;
                  win_d   = IDX_W'(cand);
                  addr_d  = bus.req_addr[cand*CPU_WIDTH +: CPU_WIDTH];
                  ctrl_d  = bus.req_ctrl[cand];
                  wdata_d = bus.req_wdata[cand*CPU_WIDTH +: CPU_WIDTH];
                  state_d = S_XFER;
               end
            end
         end
         S_XFER: begin
            if (ctrl_q == IO_CTRL_READ) rdata_d = mapped ? bus_data : UNMAPPED_RDATA;
            state_d = S_RESP;
         end
         S_RESP: begin
            rr_d    = (int'(win_q) == REQ_NUM - 1) ? '0 : win_q + IDX_W'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ack      = '0;
      bus.dev_en   = '0;
      bus.bus_ctrl = IO_CTRL_READ;
      bus.bus_addr = addr_q;
      bus.rdata    = rdata_q;
`ifdef IO_ARB_ERR_EN
      bus.err      = 1'b0;
`endif
      case (state_q)
         S_XFER: begin
            bus.bus_ctrl = ctrl_q;
            for (int i = 0; i < DEV_NUM; i++)
               bus.dev_en[i] = mapped && (32'(dev_idx) == $unsigned(i));
         end
         S_RESP: begin
            bus.ack[win_q] = 1'b1;
`ifdef IO_ARB_ERR_EN
            bus.err        = !mapped;
`endif
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_bus_arbiter : transaction-level model with per-cycle compare plus  |
// | directed literal checks. Honors IO_ARB_ERR_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module tb_io_bus_arbiter;
   localparam int CPU_WIDTH = 16;
   localparam int REQ_NUM   = 2;
   localparam int DEV_NUM   = 4;
   localparam int DEV_SHIFT = 12;
   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;
`ifdef IO_ARB_ERR_EN
   localparam logic [15:0] UNMAP_RD = 16'hDEAD;
`else
   localparam logic [15:0] UNMAP_RD = 16'h0000;
`endif
   localparam logic [15:0] SLAVE_RD [DEV_NUM] = '{16'h0F00, 16'h1111, 16'h1234, 16'h3C3C};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_en = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   wire [CPU_WIDTH-1:0] bus_data;

   io_bus_arbiter_if #(.CPU_WIDTH(CPU_WIDTH), .REQ_NUM(REQ_NUM), .DEV_NUM(DEV_NUM)) bus_if ();

   io_bus_arbiter #(
      .CPU_WIDTH(CPU_WIDTH), .REQ_NUM(REQ_NUM), .DEV_NUM(DEV_NUM), .DEV_SHIFT(DEV_SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .bus_data(bus_data)
   );

   always #5 clk = ~clk;

   for (genvar g = 0; g < CPU_WIDTH; g++) begin : g_pull
      pullup (bus_data[g]);
   end

   // Slave models: fixed read value per slave, write register per slave.
   logic        s_oe;
   logic [15:0] s_val;
   logic [15:0] slave_reg [DEV_NUM];
   always_comb begin
      s_oe  = 1'b0;
      s_val = '0;
      for (int k = 0; k < DEV_NUM; k++)
         if (bus_if.dev_en[k] && bus_if.bus_ctrl == RD) begin
            s_oe  = 1'b1;
            s_val = SLAVE_RD[k];
         end
   end
   assign bus_data = s_oe ? s_val : 'z;

   always @(posedge clk) begin
      for (int k = 0; k < DEV_NUM; k++) begin
         if (rst) slave_reg[k] <= '0;
         else if (bus_if.dev_en[k] && bus_if.bus_ctrl == WR) slave_reg[k] <= bus_data;
      end
   end

   // Transaction model: phase counts cycles since a grant (0 = idle).
   int          m_phase = 0;
   int          m_rr = 0;
   int          m_win = 0;
   int          m_next;
   logic [15:0] m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] m_rdata = '0;
   logic        m_ctrl = RD;

   function automatic int pick(input logic [REQ_NUM-1:0] r, input int p);
      for (int k = 0; k < REQ_NUM; k++)
         if (r[(p + k) % REQ_NUM]) return (p + k) % REQ_NUM;
      return -1;
   endfunction

   function automatic logic [15:0] read_value(input logic [15:0] a);
      int idx;
      idx = int'(a >> DEV_SHIFT);
      if (idx < DEV_NUM) return SLAVE_RD[idx];
      return UNMAP_RD;
   endfunction

   always_comb m_next = pick(bus_if.req, m_rr);

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_rr    <= 0;
         m_rdata <= '0;
      end else if (m_phase == 0) begin
         if (m_next >= 0) begin
            m_win   <= m_next;
            m_addr  <= bus_if.req_addr[m_next*16 +: 16];
            m_wdata <= bus_if.req_wdata[m_next*16 +: 16];
            m_ctrl  <= bus_if.req_ctrl[m_next];
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         if (m_ctrl == RD) m_rdata <= read_value(m_addr);
         m_phase <= 2;
      end else begin
         m_rr    <= (m_win + 1) % REQ_NUM;
         m_phase <= 0;
      end
   end

   int          m_idx;
   logic [1:0]  exp_ack;
   logic [3:0]  exp_dev;
   logic        exp_ctrl;
   logic [15:0] exp_data;
   logic        exp_err;
   always_comb begin
      m_idx    = int'(m_addr >> DEV_SHIFT);
      exp_ack  = '0;
      exp_dev  = '0;
      exp_ctrl = RD;
      exp_data = 16'hFFFF;
      exp_err  = 1'b0;
      if (m_phase == 1) begin
         exp_ctrl = m_ctrl;
         exp_dev  = (m_idx < DEV_NUM) ? 4'(1 << m_idx) : 4'b0;
         if (m_ctrl == WR) exp_data = m_wdata;
         else if (m_idx < DEV_NUM) exp_data = SLAVE_RD[m_idx];
      end
      if (m_phase == 2) begin
         exp_ack = 2'(1 << m_win);
         exp_err = (m_idx >= DEV_NUM);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack", 32'(bus_if.ack), 32'(exp_ack));
         chk("dev_en", 32'(bus_if.dev_en), 32'(exp_dev));
         chk("bus_ctrl", 32'(bus_if.bus_ctrl), 32'(exp_ctrl));
         chk("bus_data", 32'(bus_data), 32'(exp_data));
         chk("rdata", 32'(bus_if.rdata), 32'(m_rdata));
         if (m_phase == 1) chk("bus_addr", 32'(bus_if.bus_addr), 32'(m_addr));
`ifdef IO_ARB_ERR_EN
         chk("err", 32'(bus_if.err), 32'(exp_err));
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_req(input int m, input logic c, input logic [15:0] a, input logic [15:0] d);
      bus_if.req[m]                = 1'b1;
      bus_if.req_ctrl[m]           = c;
      bus_if.req_addr[m*16 +: 16]  = a;
      bus_if.req_wdata[m*16 +: 16] = d;
   endtask

   task automatic do_xfer(input int m, input logic c, input logic [15:0] a, input logic [15:0] d);
      logic got;
      got = 1'b0;
      set_req(m, c, a, d);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (bus_if.ack[m]) got = 1'b1;
      end
      bus_if.req[m] = 1'b0;
      chk("ack_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      bus_if.req       = '0;
      bus_if.req_ctrl  = '0;
      bus_if.req_addr  = '0;
      bus_if.req_wdata = '0;
      rst = 1'b1;
      cyc(2);
      chk_en = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("rst_ack", 32'(bus_if.ack), 32'h0);
      chk("rst_dev_en", 32'(bus_if.dev_en), 32'h0);
      chk("rst_rdata", 32'(bus_if.rdata), 32'h0);
      chk("rst_bus_ctrl", 32'(bus_if.bus_ctrl), 32'(RD));
      chk("rst_bus_addr", 32'(bus_if.bus_addr), 32'h0);
      chk("rst_bus_data_z", 32'(bus_data), 32'hFFFF);

      // Single write from master 0 to the LED slave.
      set_req(0, WR, 16'h0005, 16'h000A);
      cyc(1);
      chk("wr_dev_en", 32'(bus_if.dev_en), 32'b0001);
      chk("wr_bus_data", 32'(bus_data), 32'h000A);
      chk("wr_bus_ctrl", 32'(bus_if.bus_ctrl), 32'(WR));
      cyc(1);
      chk("wr_ack", 32'(bus_if.ack), 32'b01);
      chk("wr_led", 32'(slave_reg[0]), 32'hA);
      bus_if.req[0] = 1'b0;
      cyc(1);
      chk("wr_idle_z", 32'(bus_data), 32'hFFFF);

      // Single read from master 1, slave 2.
      set_req(1, RD, 16'h2000, 16'h0000);
      cyc(1);
      chk("rd_dev_en", 32'(bus_if.dev_en), 32'b0100);
      chk("rd_bus_data", 32'(bus_data), 32'h1234);
      cyc(1);
      chk("rd_ack", 32'(bus_if.ack), 32'b10);
      chk("rd_rdata", 32'(bus_if.rdata), 32'h1234);
      bus_if.req[1] = 1'b0;
      cyc(1);
      chk("rd_rdata_held", 32'(bus_if.rdata), 32'h1234);

      // Contention from reset with both requests held.
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      set_req(0, RD, 16'h1000, 16'h0000);
      set_req(1, WR, 16'h3000, 16'h5555);
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         chk("rr_ack", 32'(bus_if.ack),
             (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 32'b01 : 32'b10) : 32'b00);
      end
      bus_if.req = '0;
      cyc(1);
      chk("rr_wr_slave3", 32'(slave_reg[3]), 32'h5555);
      chk("rr_rdata", 32'(bus_if.rdata), 32'h1111);

      // Unmapped read.
      set_req(0, RD, 16'hF000, 16'h0000);
      cyc(1);
      chk("unm_dev_en", 32'(bus_if.dev_en), 32'h0);
      cyc(1);
      chk("unm_ack", 32'(bus_if.ack), 32'b01);
      chk("unm_rdata", 32'(bus_if.rdata), 32'(UNMAP_RD));
`ifdef IO_ARB_ERR_EN
      chk("unm_err", 32'(bus_if.err), 32'h1);
`endif
      bus_if.req[0] = 1'b0;
      cyc(1);

      // Reset during the XFER cycle of a write.
      set_req(0, WR, 16'h1004, 16'h7777);
      cyc(1);
      chk("abort_dev_en_xfer", 32'(bus_if.dev_en), 32'b0010);
      rst = 1'b1;
      bus_if.req[0] = 1'b0;
      cyc(1);
      chk("abort_dev_en", 32'(bus_if.dev_en), 32'h0);
      chk("abort_ack", 32'(bus_if.ack), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(bus_if.ack), 32'h0);
      end
      set_req(0, RD, 16'h3000, 16'h0000);
      set_req(1, RD, 16'h0000, 16'h0000);
      cyc(2);
      chk("post_rst_first", 32'(bus_if.ack), 32'b01);
      chk("post_rst_rdata0", 32'(bus_if.rdata), 32'h3C3C);
      bus_if.req[0] = 1'b0;
      cyc(3);
      chk("post_rst_second", 32'(bus_if.ack), 32'b10);
      chk("post_rst_rdata1", 32'(bus_if.rdata), 32'h0F00);
      bus_if.req[1] = 1'b0;
      cyc(1);

      // Mixed directed transfers, including index boundaries 3 and 4.
      do_xfer(1, WR, 16'h1ABC, 16'hBEEF);
      do_xfer(0, RD, 16'h1ABC, 16'h0000);
      do_xfer(1, RD, 16'h3FFF, 16'h0000);
      do_xfer(0, WR, 16'h4000, 16'h9999);
      do_xfer(1, RD, 16'hC123, 16'h0000);
      do_xfer(0, RD, 16'h2FFE, 16'h0000);
      chk("tbl_slave1", 32'(slave_reg[1]), 32'hBEEF);
      cyc(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
